// File: rtl/stream_demux.sv
// stream_demux: 1:NUM_OUT routing demultiplexer with a one-entry holding
// register per output channel.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   in_valid/ready  input handshake; in_ready is combinational from
//                   in_sel, the channel full flags and out_ready
//   in_data, in_sel input word and destination channel index
//   out_valid[k]    channel k holding register full
//   out_ready[k]    consumer k accepts this cycle
//   out_data        channel k word at bits [k*WIDTH +: WIDTH]
//   err_sel         one-cycle pulse after an out-of-range word is dropped
//   drop_count      saturating count of dropped out-of-range words

// One output lane: a single holding register with valid/ready drain.
module stream_demux_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (acc) begin
      // Covers both refill-after-drain and fill-from-empty.
      full <= 1'b1;
      dout <= din;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end
endmodule

module stream_demux #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic                     err_sel,
  output logic [15:0]              drop_count
);
  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } req_t;

  localparam logic [SEL_W:0] NOUT = (SEL_W+1)'(NUM_OUT);

  req_t                            req;
  logic                            sel_ok;
  logic                            sel_rdy;
  logic                            xfer;
  logic                            drop;
  logic [NUM_OUT-1:0]              full;
  logic [NUM_OUT-1:0]              ch_rdy;
  logic [NUM_OUT-1:0]              acc;
  logic [NUM_OUT-1:0][WIDTH-1:0]   ch_data;

  assign req    = '{vld: in_valid, sel: in_sel, data: in_data};
  assign sel_ok = {1'b0, req.sel} < NOUT;
  assign ch_rdy = ~full | out_ready;

  // Explicit lane compare keeps the lookup in range when NUM_OUT is not
  // a power of two.
  always_comb begin
    sel_rdy = 1'b0;
    for (int k = 0; k < NUM_OUT; k++)
      if (req.sel == SEL_W'(k)) sel_rdy = ch_rdy[k];
  end

  // Out-of-range words are always taken so they never stall the source.
  assign in_ready = sel_ok ? sel_rdy : 1'b1;
  assign xfer     = req.vld & in_ready;
  assign drop     = xfer & ~sel_ok;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_acc
    assign acc[k] = xfer & (req.sel == SEL_W'(k));
  end

  stream_demux_ch #(.WIDTH(WIDTH)) u_ch [NUM_OUT-1:0] (
    .clk       (clk),
    .reset     (reset),
    .acc       (acc),
    .out_ready (out_ready),
    .din       (req.data),
    .full      (full),
    .dout      (ch_data)
  );

  assign out_valid = full;
  assign out_data  = ch_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sel    <= 1'b0;
      drop_count <= '0;
    end else begin
      err_sel <= drop;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a NUM_OUT=4 instance for routing/flow control and
// a NUM_OUT=3 instance for out-of-range drops, sharing one stimulus bus.
module tb_stream_demux;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic [3:0]  out_ready = '0;

  logic        rdy4, err4, rdy3, err3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [63:0] od4;
  logic [47:0] od3;
  logic [15:0] dc4, dc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(16), .NUM_OUT(4), .SEL_W(2)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .err_sel(err4), .drop_count(dc4));

  stream_demux #(.WIDTH(16), .NUM_OUT(3), .SEL_W(2)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov3), .out_ready(out_ready[2:0]),
    .out_data(od3), .err_sel(err3), .drop_count(dc3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 2'd0, 16'h0, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          vld;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  ordy;
    bit          rdy;
    logic [3:0]  ov;
    int          ch;
    logic [15:0] cdata;
  } vec_t;

  vec_t tbl[11];

  // reference model state
  bit          has  [2][4];
  logic [15:0] word [2][4];
  bit          perr [2];
  int          cnt  [2];
  int          nout;
  bit          erdy, arw, aov, aerr;
  logic [15:0] adat, adc;

  initial begin
    // routing then back-pressure, drain-and-refill
    tbl[0]  = '{1, 2'd0, 16'hA5A5, 4'hF, 1, 4'b0000, 0, 16'h0000};
    tbl[1]  = '{1, 2'd3, 16'h1234, 4'hF, 1, 4'b0001, 0, 16'hA5A5};
    tbl[2]  = '{0, 2'd0, 16'h0000, 4'hF, 1, 4'b1000, 3, 16'h1234};
    tbl[3]  = '{0, 2'd0, 16'h0000, 4'hF, 1, 4'b0000, 3, 16'h1234};
    tbl[4]  = '{1, 2'd1, 16'h0001, 4'hD, 1, 4'b0000, 1, 16'h0000};
    tbl[5]  = '{1, 2'd1, 16'h0002, 4'hD, 0, 4'b0010, 1, 16'h0001};
    tbl[6]  = '{1, 2'd1, 16'h0002, 4'hD, 0, 4'b0010, 1, 16'h0001};
    tbl[7]  = '{1, 2'd1, 16'h0002, 4'hF, 1, 4'b0010, 1, 16'h0001};
    tbl[8]  = '{0, 2'd1, 16'h0000, 4'hD, 0, 4'b0010, 1, 16'h0002};
    tbl[9]  = '{0, 2'd1, 16'h0000, 4'hF, 1, 4'b0010, 1, 16'h0002};
    tbl[10] = '{0, 2'd1, 16'h0000, 4'hF, 1, 4'b0000, 1, 16'h0002};

    do_reset();

    // reset asserted mid-cycle with channel 2 full
    @(negedge clk); drive(1, 2'd2, 16'hBEEF, 4'b1011);
    @(negedge clk); drive(1, 2'd3, 16'h0000, 4'b1011);
    @(negedge clk); drive(0, 2'd0, 16'h0000, 4'b1011);
    #1;
    chk("pre_rst_ov4", 32'(ov4), 32'(4'b1100));
    chk("pre_rst_ch2", 32'(od4[32 +: 16]), 32'hBEEF);
    chk("pre_rst_dc3", 32'(dc3), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_ov3", 32'(ov3), 32'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rst_od4_ch%0d", k), 32'(od4[k*16 +: 16]), 32'd0);
    chk("rst_dc3", 32'(dc3), 32'd0);
    chk("rst_err3", 32'(err3), 32'd0);
    @(negedge clk); reset = 1'b0;

    // table vectors on the 4-channel instance
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(rdy4), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov4), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_ch%0d_data", i, tbl[i].ch),
          32'(od4[tbl[i].ch*16 +: 16]), 32'(tbl[i].cdata));
    end

    // independence: channel 1 stalled full, stream 10 words to channel 2
    @(negedge clk); drive(1, 2'd1, 16'h1111, 4'b1101);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(1, 2'd2, 16'h2000 + 16'(i), 4'b1101);
      #1;
      chk($sformatf("ind%0d_in_ready", i), 32'(rdy4), 32'd1);
      chk($sformatf("ind%0d_ch1_held", i), 32'({ov4[1], od4[16 +: 16]}), 32'h11111);
      if (i > 0)
        chk($sformatf("ind%0d_ch2", i), 32'({ov4[2], od4[32 +: 16]}),
            32'({1'b1, 16'h2000 + 16'(i - 1)}));
    end
    @(negedge clk); drive(0, 2'd2, 16'h0, 4'b1101);
    #1;
    chk("ind_last_ch2", 32'({ov4[2], od4[32 +: 16]}), 32'h12009);

    // full throughput on channel 3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(1, 2'd3, 16'(i), 4'hF);
      #1;
      chk($sformatf("thr%0d_in_ready", i), 32'(rdy4), 32'd1);
      if (i > 0)
        chk($sformatf("thr%0d_ch3", i), 32'({ov4[3], od4[48 +: 16]}),
            32'({1'b1, 16'(i - 1)}));
    end
    @(negedge clk); drive(0, 2'd3, 16'h0, 4'hF);
    #1;
    chk("thr_last_ch3", 32'({ov4[3], od4[48 +: 16]}), 32'h10007);

    // randomized traffic against a per-channel slot model for both instances
    do_reset();
    for (int d = 0; d < 2; d++) begin
      perr[d] = 0;
      cnt[d]  = 0;
      for (int k = 0; k < 4; k++) begin
        has[d][k]  = 0;
        word[d][k] = '0;
      end
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
            4'($urandom));
      #1;
      for (int d = 0; d < 2; d++) begin
        nout = (d == 0) ? 4 : 3;
        erdy = (int'(in_sel) >= nout) ? 1'b1 : (!has[d][in_sel] || out_ready[in_sel]);
        arw  = (d == 0) ? rdy4 : rdy3;
        aerr = (d == 0) ? err4 : err3;
        adc  = (d == 0) ? dc4 : dc3;
        chk($sformatf("rnd%0d_d%0d_in_ready", c, d), 32'(arw), 32'(erdy));
        chk($sformatf("rnd%0d_d%0d_err_sel", c, d), 32'(aerr), 32'(perr[d]));
        chk($sformatf("rnd%0d_d%0d_drop_count", c, d), 32'(adc), 32'(cnt[d]));
        for (int k = 0; k < nout; k++) begin
          aov  = (d == 0) ? ov4[k] : ov3[k];
          adat = (d == 0) ? od4[k*16 +: 16] : od3[k*16 +: 16];
          chk($sformatf("rnd%0d_d%0d_ov%0d", c, d, k), 32'(aov), 32'(has[d][k]));
          if (has[d][k])
            chk($sformatf("rnd%0d_d%0d_data%0d", c, d, k), 32'(adat), 32'(word[d][k]));
        end
        // next state from the handshake rules
        for (int k = 0; k < nout; k++) begin
          if (in_valid && erdy && int'(in_sel) == k) begin
            has[d][k]  = 1;
            word[d][k] = in_data;
          end else if (has[d][k] && out_ready[k]) begin
            has[d][k] = 0;
          end
        end
        perr[d] = in_valid && (int'(in_sel) >= nout);
        if (perr[d] && cnt[d] < 65535) cnt[d]++;
      end
    end

    // bad select on the 3-channel instance
    do_reset();
    @(negedge clk); drive(1, 2'd3, 16'h0BAD, 4'h0);
    #1;
    chk("bad0_in_ready", 32'(rdy3), 32'd1);
    chk("bad0_err_sel", 32'(err3), 32'd0);
    @(negedge clk); drive(1, 2'd3, 16'h0BAD, 4'h0);
    #1;
    chk("bad1_in_ready", 32'(rdy3), 32'd1);
    chk("bad1_err_sel", 32'(err3), 32'd1);
    chk("bad1_drop_count", 32'(dc3), 32'd1);
    @(negedge clk); drive(0, 2'd0, 16'h0, 4'h0);
    #1;
    chk("bad2_err_sel", 32'(err3), 32'd1);
    chk("bad2_drop_count", 32'(dc3), 32'd2);
    chk("bad2_out_valid", 32'(ov3), 32'd0);
    @(negedge clk);
    #1;
    chk("bad3_err_sel", 32'(err3), 32'd0);
    chk("bad3_drop_count", 32'(dc3), 32'd2);

    // saturation: bring count to FFFE, then drop 3 more
    @(negedge clk); drive(1, 2'd3, 16'h0, 4'hF);
    repeat (65532) @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    #1;
    chk("sat_fffe", 32'(dc3), 32'hFFFE);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    #1;
    chk("sat_ffff", 32'(dc3), 32'hFFFF);
    chk("sat_err_sel", 32'(err3), 32'd1);
    chk("sat_out_valid", 32'(ov3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1:NUM_OUT routing demultiplexer: one WIDTH-bit input stream is steered to one of NUM_OUT output channels, chosen per word by in_sel.
- It is the opposite direction of the datapath 2:1 selection mux: it fans a shared result bus out to consumers (register-file write port, memory write port, I/O ports).
- Each output channel has a one-entry holding register with a valid/ready handshake, so slow consumers stall only their own traffic.

Parameters:
WIDTH, 16, data word width in bits
NUM_OUT, 4, number of output channels (2..8)
SEL_W, 2, width of in_sel; must satisfy 2^SEL_W >= NUM_OUT

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  demux accepts input word this cycle
in_data  input  WIDTH  input word
in_sel  input  SEL_W  destination channel index
out_valid  output  NUM_OUT  bit k: channel k holding register full
out_ready  input  NUM_OUT  bit k: consumer k accepts this cycle
out_data  output  NUM_OUT*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
err_sel  output  1  one-cycle pulse: a word with in_sel >= NUM_OUT was dropped
drop_count  output  16  saturating count of dropped out-of-range words

Behaviour:
- Reset (async, active-high, effective immediately and independent of clk):
  - out_valid = 0; all out_data = 0; err_sel = 0; drop_count = 0.
  - In-flight words in the holding registers are discarded; there is no recovery.
- Per-channel state: full[k], mapped directly to out_valid[k], plus data register k.
- Accept rule:
  - When in_sel < NUM_OUT: in_ready = ~full[in_sel] | out_ready[in_sel].
  - When in_sel >= NUM_OUT: in_ready = 1, so bad words never deadlock the source.
  - in_ready is combinational from in_sel, full and out_ready.
  - An input transfer occurs when in_valid & in_ready at a rising edge.
- Output handshake: channel k transfers when out_valid[k] & out_ready[k] at a rising edge.
- Per-channel update at each rising edge, with acc_k = input transfer with in_sel == k:
  - acc_k and channel k drains: full stays 1; data k <= in_data (back-to-back, full throughput).
  - acc_k only: full <= 1; data k <= in_data.
  - Drain only: full <= 0; data k holds its last value.
  - Neither: hold.
- Latency: an accepted word appears on out_valid/out_data of its channel on the next cycle. Minimum 1 cycle; no combinational path from in_data to out_data.
- Independence: a stalled channel (out_ready low) never affects acceptance for other channels, except that the head input word blocks the source while it targets the stalled channel. There is no reordering and no internal queue beyond one entry per channel.
- Out-of-range select (in_sel >= NUM_OUT) with in_valid:
  - The word is accepted and dropped; no channel changes.
  - err_sel = 1 on the next cycle only. Consecutive bad words keep err_sel high for consecutive cycles.
  - drop_count increments by 1 per dropped word and saturates at 16'hFFFF.
- Stability: out_data[k] is stable while out_valid[k] = 1 and out_ready[k] = 0. Once asserted, out_valid[k] drops only after a drain.
- in_valid low: no state change. in_sel and in_data are don't-care.

Test Plan:
1. Reset then idle: assert reset mid-cycle with channel 2 full -> out_valid = 4'b0000, out_data = 0, drop_count = 0 immediately, without waiting for a clock edge.
2. Routing: send 16'hA5A5 sel 0, 16'h1234 sel 3, all out_ready = 1 -> one cycle later each word appears on the matching channel, with out_valid asserted for exactly one cycle per word.
3. Back-pressure: out_ready[1] = 0, send 16'h0001 then 16'h0002 to sel 1.
   - First word is accepted; in_ready = 0 for the second; out_data[1] holds 16'h0001.
   - Raise out_ready[1] -> same-cycle drain-and-refill; 16'h0002 appears the next cycle.
4. Independence: channel 1 stalled and full, stream 10 words to sel 2 with out_ready[2] = 1 -> all 10 are accepted consecutively with 1-cycle latency and in order.
5. Full throughput: out_ready[3] = 1, in_valid held high with sel 3 for 8 cycles with data 0..7 -> in_ready is 1 every cycle and out_data[3] shows 0..7 in consecutive cycles.
6. Bad select (NUM_OUT = 3, SEL_W = 2):
   - Send sel 3 twice -> in_ready = 1, err_sel high for 2 cycles, drop_count = 2, no out_valid change.
   - Force drop_count to 16'hFFFE then drop 3 more words -> drop_count holds at 16'hFFFF.
